// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand sequencer slice.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        EXEC  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Saturation limits at the default width; the top derives width-generic equivalents.
    localparam logic [ALU_WIDTH-1:0] SAT_MAX = 8'h7F;
    localparam logic [ALU_WIDTH-1:0] SAT_MIN = 8'h80;

endpackage

// File: rtl/alu_ovf_counter.sv
// Saturating event counter: counts up on inc_i and sticks at all-ones.
module alu_ovf_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Sequencer in front of the adder_subtractor: collects A then B, pulses the adder
// enable for one execute cycle, and holds the registered result until accepted.
// Optional build macro ALU_SATURATE_EN clamps overflowed results toward the sign of A.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_op,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_op,
    output logic             add_en,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_count
);

`ifdef ALU_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_op_q, add_op_d;
    logic             add_en_q, add_en_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic             ovf_inc;

    // B and op land directly in the adder-facing registers, which double as B_reg/op_reg.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_op_d    = add_op_q;
        add_en_d    = add_en_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        ovf_inc     = 1'b0;

        case (state_q)
            GET_A: begin
                if (in_valid) begin
                    a_d     = in_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (in_valid) begin
                    add_a_d    = a_q;
                    add_b_d    = in_data;
                    add_op_d   = in_op;
                    add_en_d   = 1'b1;
                    in_ready_d = 1'b0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                out_data_d = add_s;
`ifdef ALU_SATURATE_EN
                if (add_ovf) begin
                    out_data_d = add_a_q[WIDTH-1] ? SAT_LO : SAT_HI;
                end
`endif
                out_ovf_d   = add_ovf;
                out_valid_d = 1'b1;
                add_en_d    = 1'b0;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    ovf_inc     = out_ovf_q;
                    state_d     = GET_A;
                end
            end
            default: begin
                state_d = GET_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GET_A;
            a_q         <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_op_q    <= OP_ADD;
            add_en_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_op_q    <= add_op_d;
            add_en_q    <= add_en_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    alu_ovf_counter #(
        .CNT_W(CNT_W)
    ) u_ovf_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (ovf_inc),
        .count_o(ovf_count)
    );

    assign in_ready  = in_ready_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_op    = add_op_q;
    assign add_en    = add_en_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural 8-bit adder_subtractor.
module tb_alu_operand_sequencer;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 2;

`ifdef ALU_SATURATE_EN
    localparam logic [7:0] E_P127_ADD_1  = 8'h7F;
    localparam logic [7:0] E_M128_SUB_1  = 8'h80;
    localparam logic [7:0] E_100_ADD_100 = 8'h7F;
    localparam logic [7:0] E_M100_SUB_100 = 8'h80;
    localparam logic [7:0] E_64_ADD_64   = 8'h7F;
`else
    localparam logic [7:0] E_P127_ADD_1  = 8'h80;
    localparam logic [7:0] E_M128_SUB_1  = 8'h7F;
    localparam logic [7:0] E_100_ADD_100 = 8'hC8;
    localparam logic [7:0] E_M100_SUB_100 = 8'h38;
    localparam logic [7:0] E_64_ADD_64   = 8'h80;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_op;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_op;
    logic          add_en;
    logic [W-1:0]  add_s;
    logic          add_ovf;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_ovf;
    logic [CW-1:0] ovf_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_op    (in_op),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_op   (add_op),
        .add_en   (add_en),
        .add_s    (add_s),
        .add_ovf  (add_ovf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .ovf_count(ovf_count)
    );

    // Idle adder returns a junk pattern so a capture outside EXEC is visible.
    always_comb begin
        add_s   = 8'hA5;
        add_ovf = 1'b0;
        if (add_en) begin
            if (add_op) begin
                add_s   = add_a - add_b;
                add_ovf = (add_a[7] != add_b[7]) && (add_s[7] != add_a[7]);
            end else begin
                add_s   = add_a + add_b;
                add_ovf = (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT just after the edge that accepted B (EXEC cycle).
    task automatic load_ab(input string tag, input logic [7:0] a, input logic [7:0] b, input logic op);
        in_valid = 1'b1;
        in_data  = a;
        in_op    = ~op;
        tick;
        chk({tag, " getb_en"}, 32'(add_en), 32'd0);
        chk({tag, " getb_rdy"}, 32'(in_ready), 32'd1);
        in_data = b;
        in_op   = op;
        tick;
        in_valid = 1'b0;
        in_data  = '0;
        in_op    = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic op,
                          input logic [7:0] exp_d, input logic exp_o, input logic [CW-1:0] exp_cnt);
        load_ab(tag, a, b, op);
        chk({tag, " exec_en"}, 32'(add_en), 32'd1);
        chk({tag, " exec_a"}, 32'(add_a), 32'(a));
        chk({tag, " exec_b"}, 32'(add_b), 32'(b));
        chk({tag, " exec_op"}, 32'(add_op), 32'(op));
        chk({tag, " exec_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, " exec_vld"}, 32'(out_valid), 32'd0);
        tick;
        chk({tag, " vld"}, 32'(out_valid), 32'd1);
        chk({tag, " data"}, 32'(out_data), 32'(exp_d));
        chk({tag, " ovf"}, 32'(out_ovf), 32'(exp_o));
        chk({tag, " hold_en"}, 32'(add_en), 32'd0);
        chk({tag, " hold_a"}, 32'(add_a), 32'(a));
        tick;
        chk({tag, " done_vld"}, 32'(out_valid), 32'd0);
        chk({tag, " done_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, " cnt"}, 32'(ovf_count), 32'(exp_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst add_a", 32'(add_a), 32'd0);
        chk("rst add_b", 32'(add_b), 32'd0);
        chk("rst add_op", 32'(add_op), 32'd0);
        chk("rst add_en", 32'(add_en), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst out_ovf", 32'(out_ovf), 32'd0);
        chk("rst ovf_count", 32'(ovf_count), 32'd0);
        rst_n = 1'b1;
        tick;
        chk("idle add_en", 32'(add_en), 32'd0);

        run_op("1+1", 8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 2'd0);
        run_op("127+1", 8'h7F, 8'h01, 1'b0, E_P127_ADD_1, 1'b1, 2'd1);
        run_op("-128-1", 8'h80, 8'h01, 1'b1, E_M128_SUB_1, 1'b1, 2'd2);
        run_op("-127-1", 8'h81, 8'h01, 1'b1, 8'h80, 1'b0, 2'd2);

        // Backpressure: -1 + -1 held for 5 cycles while a stray operand is offered.
        out_ready = 1'b0;
        load_ab("bp", 8'hFF, 8'hFF, 1'b0);
        tick;
        in_valid = 1'b1;
        in_data  = 8'h33;
        for (int i = 0; i < 5; i++) begin
            chk("bp vld", 32'(out_valid), 32'd1);
            chk("bp data", 32'(out_data), 32'hFE);
            chk("bp ovf", 32'(out_ovf), 32'd0);
            chk("bp rdy", 32'(in_ready), 32'd0);
            tick;
        end
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick;
        chk("bp done_vld", 32'(out_valid), 32'd0);
        chk("bp done_rdy", 32'(in_ready), 32'd1);
        chk("bp cnt", 32'(ovf_count), 32'd2);

        // Asynchronous reset while in EXEC.
        load_ab("rx", 8'd10, 8'd20, 1'b1);
        chk("rx pre_en", 32'(add_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rx add_en", 32'(add_en), 32'd0);
        chk("rx in_ready", 32'(in_ready), 32'd1);
        chk("rx add_a", 32'(add_a), 32'd0);
        chk("rx add_b", 32'(add_b), 32'd0);
        chk("rx add_op", 32'(add_op), 32'd0);
        chk("rx out_valid", 32'(out_valid), 32'd0);
        chk("rx ovf_count", 32'(ovf_count), 32'd0);
        #1 rst_n = 1'b1;
        run_op("rx 5-3", 8'd5, 8'd3, 1'b1, 8'd2, 1'b0, 2'd0);

        // Asynchronous reset while an overflowed result waits in HOLD.
        out_ready = 1'b0;
        load_ab("rh", 8'h7F, 8'h01, 1'b0);
        tick;
        chk("rh pre_vld", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rh out_valid", 32'(out_valid), 32'd0);
        chk("rh out_data", 32'(out_data), 32'd0);
        chk("rh out_ovf", 32'(out_ovf), 32'd0);
        chk("rh in_ready", 32'(in_ready), 32'd1);
        chk("rh add_a", 32'(add_a), 32'd0);
        chk("rh ovf_count", 32'(ovf_count), 32'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        run_op("rh 5-3", 8'd5, 8'd3, 1'b1, 8'd2, 1'b0, 2'd0);

        // Five overflow results in a row: 2-bit counter sticks at 3.
        run_op("sat1", 8'h7F, 8'h01, 1'b0, E_P127_ADD_1, 1'b1, 2'd1);
        run_op("sat2", 8'h80, 8'h01, 1'b1, E_M128_SUB_1, 1'b1, 2'd2);
        run_op("sat3", 8'd100, 8'd100, 1'b0, E_100_ADD_100, 1'b1, 2'd3);
        run_op("sat4", 8'h9C, 8'd100, 1'b1, E_M100_SUB_100, 1'b1, 2'd3);
        run_op("sat5", 8'd64, 8'd64, 1'b0, E_64_ADD_64, 1'b1, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
